fifo_byte_packer: RTL

FIFO_BYTE_PACKER -- requirements
Module: fifo_byte_packer

---
 rtl/fifo_byte_packer_pkg.sv | 19 +
 rtl/fifo_byte_packer_if.sv | 37 +++
 rtl/fifo_byte_packer_slot.sv | 49 ++++
 rtl/fifo_byte_packer.sv | 111 +++++++++++
 4 files changed

// File: rtl/fifo_byte_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : fifo_pack_pkg                                              |
// | Shared constants and state encoding for the FIFO byte packer.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_pack_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int OUT_BYTES_W        = 3;

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_byte_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : fifo_byte_packer_if                                      |
// | FIFO read side plus packed-word output stream of the byte packer.    |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
interface fifo_byte_packer_if
  import fifo_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = 16
);

  logic [BYTE_W-1:0]                rdata;
  logic                             rempty;
  logic                             rinc;
  logic                             flush;
  logic [BYTE_W*BYTES_PER_WORD-1:0] out_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [OUT_BYTES_W-1:0]           out_bytes;
  logic [CNT_W-1:0]                 word_count;

  // Packer side: pops the FIFO and sources the word stream.
  modport master (
    input  rdata, rempty, flush, out_ready,
    output rinc, out_data, out_valid, out_bytes, word_count
  );

  // Environment side: FIFO, flush requester and word consumer.
  modport slave (
    output rdata, rempty, flush, out_ready,
    input  rinc, out_data, out_valid, out_bytes, word_count
  );

endinterface
`default_nettype wire

// File: rtl/fifo_byte_packer_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pack_out_slot                                              |
// | Single-entry output register with valid/ready hold behaviour.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pack_out_slot
  import fifo_pack_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   load_i,
  input  wire logic [WORD_W-1:0]      load_data_i,
  input  wire logic [OUT_BYTES_W-1:0] load_bytes_i,
  input  wire logic                   ready_i,
  output logic [WORD_W-1:0]           data_o,
  output logic [OUT_BYTES_W-1:0]      bytes_o,
  output logic                        valid_o,
  output logic                        slot_free_o
);

  logic [WORD_W-1:0]      data_q;
  logic [OUT_BYTES_W-1:0] bytes_q;
  logic                   valid_q;

  // Load has priority over accept so a same-edge accept+load keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      bytes_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      bytes_q <= load_bytes_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o      = data_q;
  assign bytes_o     = bytes_q;
  assign valid_o     = valid_q;
  assign slot_free_o = !valid_q || ready_i;

endmodule
`default_nettype wire

// File: rtl/fifo_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fifo_byte_packer                                           |
// | Packs bytes from a show-ahead FIFO into little-endian words, with    |
// | flush of partial words and a wrapping emitted-word counter.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_byte_packer
  import fifo_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = 16
) (
  input wire logic           rclk,
  input wire logic           rrst,
  fifo_byte_packer_if.master bus
);

  localparam int                WORD_W   = BYTE_W * BYTES_PER_WORD;
  localparam int                IDX_W    = $clog2(BYTES_PER_WORD + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       fill_q, fill_d;
  logic [WORD_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   w_slot_free;
  logic                   w_pop;
  logic                   w_last_pop;
  logic                   w_flush_load;
  logic                   w_load;
  logic [WORD_W-1:0]      w_load_data;
  logic [OUT_BYTES_W-1:0] w_load_bytes;

  // The last byte of a word may only be popped when the slot can take the word.
  assign w_pop        = !bus.rempty && !rrst && (state_q == S_FILL) &&
                        ((fill_q < LAST_IDX) || w_slot_free);
  assign w_last_pop   = w_pop && (fill_q == LAST_IDX);
  assign w_flush_load = (state_q == S_FLUSH) && w_slot_free && (fill_q != '0);
  assign w_load       = w_last_pop || w_flush_load;

  assign bus.rinc       = w_pop;
  assign bus.word_count = cnt_q;

  // Merge the head byte into the accumulator and build the word to load.
  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    cnt_d        = cnt_q;
    w_load_data  = acc_q;
    w_load_bytes = OUT_BYTES_W'(fill_q);
    if (w_pop) begin
      w_load_data[int'(fill_q)*BYTE_W +: BYTE_W] = bus.rdata;
    end
    if (w_last_pop) begin
      w_load_bytes = OUT_BYTES_W'(BYTES_PER_WORD);
    end
    if (w_load) begin
      // Clearing the accumulator keeps unused upper bytes of partial words zero.
      acc_d  = '0;
      fill_d = '0;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (w_pop) begin
      acc_d  = w_load_data;
      fill_d = fill_q + IDX_W'(1);
    end
  end

  // Next-state logic: flush parks the packer until the partial word is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (bus.flush) state_d = S_FLUSH;
      S_FLUSH: if ((fill_q == '0) || w_slot_free) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // State, accumulator, fill index and word counter registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  pack_out_slot #(
    .WORD_W (WORD_W)
  ) u_slot (
    .clk          (rclk),
    .rst          (rrst),
    .load_i       (w_load),
    .load_data_i  (w_load_data),
    .load_bytes_i (w_load_bytes),
    .ready_i      (bus.out_ready),
    .data_o       (bus.out_data),
    .bytes_o      (bus.out_bytes),
    .valid_o      (bus.out_valid),
    .slot_free_o  (w_slot_free)
  );

endmodule
`default_nettype wire
